// File: rtl/alu_dual_issue_scheduler.sv
// ---------------------------------------------------------------------------
// alu_dual_issue_scheduler
//
// In-order dual-issue scheduler placed in front of the 4-lane register file /
// ALU datapath (lane 0 arithmetic, 1 logic, 2 left shift, 3 right shift).
// Incoming micro-ops are buffered in a FIFO. Each cycle up to two ops are
// issued from the FIFO head onto distinct lanes. The per-lane register
// selects, op codes and write enables are registered outputs.
//
// Micro-op layout (MSB first): {lane[1:0], op[1:0], dst, src_a, src_b}
//
// Ports:
//   clk_i            clock
//   rst_ni           synchronous active-low reset
//   op_valid_i       micro-op offered
//   op_ready_o       FIFO can accept (0 while in reset)
//   op_data_i        micro-op payload
//   hold_i           suppress issue this cycle
//   select_a_o       per-lane A read address
//   select_b_o       per-lane B read address
//   select_r_o       per-lane write address
//   lane_op_o        per-lane op code
//   enable_writing_o per-lane write enable
//   select_flags_o   lane of the oldest op issued last cycle (holds otherwise)
//   pair_issue_o     two ops issued last cycle
//   empty_o          FIFO empty
//   issued_cnt_o     total ops issued, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module alu_dual_issue_scheduler #(
  parameter int DEPTH         = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                op_valid_i,
  output logic                                op_ready_o,
  input  logic [4+3*ADDRESS_WIDTH-1:0]        op_data_i,
  input  logic                                hold_i,
  output logic [3:0][ADDRESS_WIDTH-1:0]       select_a_o,
  output logic [3:0][ADDRESS_WIDTH-1:0]       select_b_o,
  output logic [3:0][ADDRESS_WIDTH-1:0]       select_r_o,
  output logic [3:0][1:0]                     lane_op_o,
  output logic [3:0]                          enable_writing_o,
  output logic [1:0]                          select_flags_o,
  output logic                                pair_issue_o,
  output logic                                empty_o,
  output logic [CNT_WIDTH-1:0]                issued_cnt_o
);

  localparam int A     = ADDRESS_WIDTH;
  localparam int W     = 4 + 3 * A;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;

  // Registered datapath controls
  logic [3:0][A-1:0] sel_a_reg, sel_a_next;
  logic [3:0][A-1:0] sel_b_reg, sel_b_next;
  logic [3:0][A-1:0] sel_r_reg, sel_r_next;
  logic [3:0][1:0]   lane_op_reg, lane_op_next;
  logic [3:0]        en_reg, en_next;
  logic [1:0]        flags_reg, flags_next;
  logic              pair_reg, pair_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

  // Head decode
  logic [W-1:0] head0, head1;
  logic [1:0]   lane0, lane1, op0, op1;
  logic [A-1:0] dst0, dst1, a0, a1, b0, b1;
  logic         issue0, issue1, push;
  logic [1:0]   pop_cnt;

  assign head0 = mem_reg[rd_ptr_reg];
  assign head1 = mem_reg[rd_ptr_reg + PTR_W'(1)];

  assign lane0 = head0[W-1 -: 2];
  assign op0   = head0[W-3 -: 2];
  assign dst0  = head0[3*A-1 -: A];
  assign a0    = head0[2*A-1 -: A];
  assign b0    = head0[A-1:0];

  assign lane1 = head1[W-1 -: 2];
  assign op1   = head1[W-3 -: 2];
  assign dst1  = head1[3*A-1 -: A];
  assign a1    = head1[2*A-1 -: A];
  assign b1    = head1[A-1:0];

  // Ready is forced low during reset so nothing is accepted that reset
  // would immediately discard.
  assign op_ready_o = rst_ni && (count_reg < DEPTH_C);
  assign push       = op_valid_i && op_ready_o;

  // The younger op may only join the head op when it uses a different lane
  // and neither reads nor overwrites the head's destination.
  assign issue0 = !hold_i && (count_reg != '0);
  assign issue1 = issue0 && (count_reg >= (PTR_W + 1)'(2)) &&
                  (lane1 != lane0) &&
                  (dst0 != a1) && (dst0 != b1) && (dst0 != dst1);

  assign pop_cnt = {1'b0, issue0} + {1'b0, issue1};

  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop_cnt);
  assign wr_ptr_next = wr_ptr_reg + PTR_W'(push);
  assign count_next  = count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop_cnt);

  // Per-lane output steering. The two issued ops always sit on distinct
  // lanes, so at most one of hit0/hit1 is set for any lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit0, hit1;
      assign hit0 = issue0 && (lane0 == LANE);
      assign hit1 = issue1 && (lane1 == LANE);
      assign sel_a_next[gi]   = hit0 ? a0   : (hit1 ? a1   : '0);
      assign sel_b_next[gi]   = hit0 ? b0   : (hit1 ? b1   : '0);
      assign sel_r_next[gi]   = hit0 ? dst0 : (hit1 ? dst1 : '0);
      assign lane_op_next[gi] = hit0 ? op0  : (hit1 ? op1  : 2'b00);
      assign en_next[gi]      = hit0 || hit1;
    end
  endgenerate

  assign flags_next = issue0 ? lane0 : flags_reg;
  assign pair_next  = issue1;
  assign cnt_next   = cnt_reg + CNT_WIDTH'(pop_cnt);

  // Payload storage carries no reset; stale entries are never read because
  // the pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= op_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      sel_a_reg   <= '0;
      sel_b_reg   <= '0;
      sel_r_reg   <= '0;
      lane_op_reg <= '0;
      en_reg      <= '0;
      flags_reg   <= '0;
      pair_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      sel_a_reg   <= sel_a_next;
      sel_b_reg   <= sel_b_next;
      sel_r_reg   <= sel_r_next;
      lane_op_reg <= lane_op_next;
      en_reg      <= en_next;
      flags_reg   <= flags_next;
      pair_reg    <= pair_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign select_a_o       = sel_a_reg;
  assign select_b_o       = sel_b_reg;
  assign select_r_o       = sel_r_reg;
  assign lane_op_o        = lane_op_reg;
  assign enable_writing_o = en_reg;
  assign select_flags_o   = flags_reg;
  assign pair_issue_o     = pair_reg;
  assign empty_o          = (count_reg == '0);
  assign issued_cnt_o     = cnt_reg;

endmodule
